amc13_event_packer: RTL and testbench

//  Frames one event per trigger descriptor into AMC13 DAQ words for amc13_link_tx.
//  The event is two header words, trg_len payload words and one trailer word.
//  It drives ev_data*, and amc13_link_tx drives daq_ready as backpressure.
//  It runs entirely on usr_clk, so ev_data_clk of amc13_link_tx is tied to usr_clk.

---
 rtl/amc13_event_packer.sv | 175 +++++++++++++++++
 tb/tb_amc13_event_packer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amc13_event_packer.sv
// amc13_event_packer: frames one trigger descriptor plus its payload into AMC13 DAQ words
// (HDR1, HDR2, payload or pad words, TRAILER) for amc13_link_tx.
// Latency: a word issued in cycle N, when daq_ready=1, appears registered on ev_data* in N+1.
// Backpressure: daq_ready=0 holds the state and drops pl_ready, except in DRAIN, which always
// consumes payload.
// Ports: usr_clk/reset (sync, active-high); trg_* descriptor handshake; pl_* payload stream;
//        daq_ready link backpressure; ev_data* registered output word; evt_cnt/len_err_cnt counters.
module amc13_event_packer #(
  parameter logic [3:0]  AMC_NO   = 4'h1,
  parameter logic [15:0] BOARD_ID = 16'h0000,
  parameter logic [63:0] PAD_WORD = 64'hDEADBEEF_DEADBEEF
) (
  input  logic        usr_clk,
  input  logic        reset,
  input  logic        trg_valid,
  output logic        trg_ready,
  input  logic [23:0] trg_evn,
  input  logic [11:0] trg_bxn,
  input  logic [15:0] trg_orn,
  input  logic [11:0] trg_len,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic [63:0] pl_data,
  input  logic        pl_last,
  input  logic        daq_ready,
  output logic        ev_data_valid,
  output logic        ev_data_header,
  output logic        ev_data_trailer,
  output logic [63:0] ev_data,
  output logic [31:0] evt_cnt,
  output logic [15:0] len_err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR1, S_HDR2, S_PAYLOAD, S_PAD, S_DRAIN, S_TRAILER
  } state_t;

  state_t      state_q;
  logic [23:0] evn_q;
  logic [11:0] bxn_q;
  logic [15:0] orn_q;
  logic [11:0] len_q;
  logic [19:0] wc_q;
  logic [31:0] xsum_q;
  logic [11:0] pcnt_q;
  logic        err_q;
  logic [31:0] evt_cnt_q;
  logic [15:0] len_err_cnt_q;
  logic        vld_q, hdr_q, trl_q;
  logic [63:0] data_q;

  // Word selected for this cycle; issue_d says whether it actually goes out.
  logic        issue_d;
  logic        hdr_d, trl_d;
  logic [63:0] word_d;

  always_comb begin
    issue_d = 1'b0;
    hdr_d   = 1'b0;
    trl_d   = 1'b0;
    word_d  = 64'h0;
    unique case (state_q)
      S_HDR1: begin
        issue_d = daq_ready;
        hdr_d   = 1'b1;
        word_d  = {4'h0, AMC_NO, evn_q, bxn_q, wc_q};
      end
      S_HDR2: begin
        issue_d = daq_ready;
        word_d  = {orn_q, 32'h0, BOARD_ID};
      end
      S_PAYLOAD: begin
        issue_d = daq_ready & pl_valid;
        word_d  = pl_data;
      end
      S_PAD: begin
        issue_d = daq_ready;
        word_d  = PAD_WORD;
      end
      S_TRAILER: begin
        issue_d = daq_ready;
        trl_d   = 1'b1;
        word_d  = {xsum_q, evn_q[7:0], 4'h0, wc_q};
      end
      default: ;
    endcase
  end

  assign trg_ready       = (state_q == S_IDLE);
  // DRAIN discards words, so it never needs the link to be ready.
  assign pl_ready        = (state_q == S_DRAIN) || ((state_q == S_PAYLOAD) && daq_ready);
  assign ev_data_valid   = vld_q;
  assign ev_data_header  = hdr_q;
  assign ev_data_trailer = trl_q;
  assign ev_data         = data_q;
  assign evt_cnt         = evt_cnt_q;
  assign len_err_cnt     = len_err_cnt_q;

  always_ff @(posedge usr_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      evn_q         <= '0;
      bxn_q         <= '0;
      orn_q         <= '0;
      len_q         <= '0;
      wc_q          <= '0;
      xsum_q        <= '0;
      pcnt_q        <= '0;
      err_q         <= 1'b0;
      evt_cnt_q     <= '0;
      len_err_cnt_q <= '0;
      vld_q         <= 1'b0;
      hdr_q         <= 1'b0;
      trl_q         <= 1'b0;
      data_q        <= '0;
    end else begin
      vld_q  <= issue_d;
      hdr_q  <= issue_d & hdr_d;
      trl_q  <= issue_d & trl_d;
      data_q <= issue_d ? word_d : 64'h0;
      // Every issued word except the trailer folds into the checksum.
      if (issue_d && !trl_d)
        xsum_q <= xsum_q ^ word_d[63:32] ^ word_d[31:0];

      unique case (state_q)
        S_IDLE: if (trg_valid) begin
          evn_q   <= trg_evn;
          bxn_q   <= trg_bxn;
          orn_q   <= trg_orn;
          len_q   <= trg_len;
          wc_q    <= {8'h00, trg_len} + 20'd3;
          xsum_q  <= '0;
          pcnt_q  <= '0;
          err_q   <= 1'b0;
          state_q <= S_HDR1;
        end
        S_HDR1: if (daq_ready) state_q <= S_HDR2;
        S_HDR2: if (daq_ready) begin
          if (len_q != 12'd0) begin
            state_q <= S_PAYLOAD;
          end else if (pl_valid) begin
            // Payload offered for an empty event: swallow it as an error.
            err_q   <= 1'b1;
            state_q <= S_DRAIN;
          end else begin
            state_q <= S_TRAILER;
          end
        end
        S_PAYLOAD: if (daq_ready && pl_valid) begin
          pcnt_q <= pcnt_q + 12'd1;
          if (pcnt_q + 12'd1 == len_q) begin
            if (!pl_last) err_q <= 1'b1;
            state_q <= pl_last ? S_TRAILER : S_DRAIN;
          end else if (pl_last) begin
            err_q   <= 1'b1;
            state_q <= S_PAD;
          end
        end
        S_PAD: if (daq_ready) begin
          pcnt_q <= pcnt_q + 12'd1;
          if (pcnt_q + 12'd1 == len_q) state_q <= S_TRAILER;
        end
        S_DRAIN: if (pl_valid && pl_last) state_q <= S_TRAILER;
        S_TRAILER: if (daq_ready) begin
          evt_cnt_q <= evt_cnt_q + 32'd1;
          if (err_q && (len_err_cnt_q != 16'hFFFF))
            len_err_cnt_q <= len_err_cnt_q + 16'd1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amc13_event_packer.sv
// tb_amc13_event_packer: directed scenarios for amc13_event_packer.
// Latency: n/a (testbench).
// Backpressure: daq_ready driven per scenario, payload source obeys pl_ready.
module tb_amc13_event_packer;
  logic        usr_clk = 1'b0;
  logic        reset = 1'b1;
  logic        trg_valid = 1'b0, trg_ready;
  logic [23:0] trg_evn = '0;
  logic [11:0] trg_bxn = '0;
  logic [15:0] trg_orn = '0;
  logic [11:0] trg_len = '0;
  logic        pl_valid = 1'b0, pl_ready;
  logic [63:0] pl_data = '0;
  logic        pl_last = 1'b0;
  logic        daq_ready = 1'b1;
  logic        ev_data_valid, ev_data_header, ev_data_trailer;
  logic [63:0] ev_data;
  logic [31:0] evt_cnt;
  logic [15:0] len_err_cnt;

  amc13_event_packer dut (
    .usr_clk(usr_clk), .reset(reset),
    .trg_valid(trg_valid), .trg_ready(trg_ready),
    .trg_evn(trg_evn), .trg_bxn(trg_bxn), .trg_orn(trg_orn), .trg_len(trg_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data), .pl_last(pl_last),
    .daq_ready(daq_ready),
    .ev_data_valid(ev_data_valid), .ev_data_header(ev_data_header),
    .ev_data_trailer(ev_data_trailer), .ev_data(ev_data),
    .evt_cnt(evt_cnt), .len_err_cnt(len_err_cnt)
  );

  always #2 usr_clk = ~usr_clk;

  int vectors = 0;
  int miscompares = 0;

  // Output capture, sampled on the falling edge.
  logic [63:0] cap_w[$];
  bit          cap_h[$];
  bit          cap_t[$];
  int          cap_c[$];
  int          trl_cnt = 0;
  int          gap_viol = 0;
  int          mcyc = 0;
  logic        daq_prev = 1'b1;

  always @(negedge usr_clk) begin
    if (ev_data_valid) begin
      cap_w.push_back(ev_data);
      cap_h.push_back(ev_data_header);
      cap_t.push_back(ev_data_trailer);
      cap_c.push_back(mcyc);
      if (ev_data_trailer) trl_cnt++;
      if (!daq_prev) gap_viol++;
    end
    daq_prev = daq_ready;
    mcyc++;
  end

  logic [63:0] exp_w[$];
  int          pl_idx;
  bit          saw_plr;

  function automatic logic [63:0] pw(input int i);
    return 64'h0123_4567_89AB_CDEF + 64'(i) * 64'h0000_1111_0000_1111;
  endfunction

  task automatic clear_cap();
    cap_w.delete(); cap_h.delete(); cap_t.delete(); cap_c.delete();
    trl_cnt = 0; gap_viol = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; trg_valid = 1'b0; pl_valid = 1'b0; pl_last = 1'b0;
    pl_data = '0; daq_ready = 1'b1;
    repeat (2) @(posedge usr_clk);
    #1 reset = 1'b0;
    clear_cap();
  endtask

  // Reference event: headers, the first min(n_real,len) source words, pads, trailer.
  task automatic build_exp(input logic [23:0] evn, input logic [11:0] bxn,
                           input logic [15:0] orn, input logic [11:0] len, input int n_real);
    logic [19:0] wc;
    logic [31:0] x;
    exp_w.delete();
    wc = {8'h00, len} + 20'd3;
    exp_w.push_back({4'h0, 4'h1, evn, bxn, wc});
    exp_w.push_back({orn, 32'h0, 16'h0000});
    for (int i = 0; i < int'(len); i++)
      exp_w.push_back(i < n_real ? pw(i) : 64'hDEADBEEF_DEADBEEF);
    x = '0;
    foreach (exp_w[i]) x = x ^ exp_w[i][63:32] ^ exp_w[i][31:0];
    exp_w.push_back({x, evn[7:0], 4'h0, wc});
  endtask

  // mode 0: daq_ready always 1; mode 1: repeating 1,0,0,1. stop_cyc>0 aborts early.
  task automatic run_event(input logic [23:0] evn, input logic [11:0] bxn,
                           input logic [15:0] orn, input logic [11:0] len,
                           input int nwords, input int last_pos, input int mode,
                           input int stop_cyc);
    int cyc;
    bit hs_trg, hs_pl;
    trg_evn = evn; trg_bxn = bxn; trg_orn = orn; trg_len = len;
    trg_valid = 1'b1; pl_idx = 0; saw_plr = 1'b0; cyc = 0;
    while (trl_cnt == 0 && cyc < 400 && (stop_cyc == 0 || cyc < stop_cyc)) begin
      daq_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      pl_valid  = (pl_idx < nwords);
      pl_data   = pw(pl_idx);
      pl_last   = (pl_idx == last_pos);
      @(negedge usr_clk);
      hs_trg = trg_valid && trg_ready;
      hs_pl  = pl_valid && pl_ready;
      if (pl_ready) saw_plr = 1'b1;
      @(posedge usr_clk);
      #1;
      if (hs_trg) trg_valid = 1'b0;
      if (hs_pl) pl_idx++;
      cyc++;
    end
    trg_valid = 1'b0; pl_valid = 1'b0; pl_last = 1'b0; daq_ready = 1'b1;
    if (stop_cyc == 0) begin
      vectors++;
      if (trl_cnt == 0) begin
        miscompares++;
        $display("FAIL timeout: trailers seen %0d, required 1 within 400 cycles", trl_cnt);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge usr_clk);
    vectors++;
    if ({ev_data_valid, ev_data_header, ev_data_trailer, pl_ready, trg_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_ctl: got v%b h%b t%b plr%b trr%b, required 0 0 0 0 1",
               ev_data_valid, ev_data_header, ev_data_trailer, pl_ready, trg_ready);
    end
    vectors++;
    if (ev_data !== 64'h0 || evt_cnt !== 32'h0 || len_err_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got data %h evt %0d err %0d, required 0 0 0", ev_data, evt_cnt, len_err_cnt);
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_event(24'h123456, 12'hABC, 16'h7777, 12'd2, 2, 1, 0, 0);
    build_exp(24'h123456, 12'hABC, 16'h7777, 12'd2, 2);
    vectors++;
    if (cap_w.size() != exp_w.size()) begin
      miscompares++;
      $display("FAIL basic_count: got %0d words, required %0d", cap_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
      vectors++;
      if (cap_w[i] !== exp_w[i] || cap_h[i] !== (i == 0) || cap_t[i] !== (i == exp_w.size() - 1)) begin
        miscompares++;
        $display("FAIL basic_word%0d: got %h h%0b t%0b, required %h h%0b t%0b", i, cap_w[i],
                 cap_h[i], cap_t[i], exp_w[i], i == 0, i == exp_w.size() - 1);
      end
    end
    vectors++;
    if (cap_c.size() < 5 || cap_c[cap_c.size() - 1] - cap_c[0] != 4) begin
      miscompares++;
      $display("FAIL basic_contig: got %0d words not contiguous over 5 cycles, required 5 contiguous", cap_c.size());
    end
    vectors++;
    if (evt_cnt !== 32'd1 || len_err_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL basic_cnt: got evt %0d err %0d, required 1 0", evt_cnt, len_err_cnt);
    end
  endtask

  task automatic test_len0();
    do_reset();
    run_event(24'h000001, 12'h002, 16'h0003, 12'd0, 0, -1, 0, 0);
    exp_w.delete();
    exp_w.push_back(64'h01000001_00200003);
    exp_w.push_back(64'h00030000_00000000);
    exp_w.push_back(64'h01230002_01000003);
    vectors++;
    if (cap_w.size() != 3) begin
      miscompares++;
      $display("FAIL len0_count: got %0d words, required 3", cap_w.size());
    end
    for (int i = 0; i < 3 && i < cap_w.size(); i++) begin
      vectors++;
      if (cap_w[i] !== exp_w[i] || cap_h[i] !== (i == 0) || cap_t[i] !== (i == 2)) begin
        miscompares++;
        $display("FAIL len0_word%0d: got %h h%0b t%0b, required %h h%0b t%0b", i, cap_w[i],
                 cap_h[i], cap_t[i], exp_w[i], i == 0, i == 2);
      end
    end
    vectors++;
    if (saw_plr !== 1'b0 || len_err_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL len0_plr: got pl_ready_seen %0b err %0d, required 0 0", saw_plr, len_err_cnt);
    end
  endtask

  task automatic test_pad();
    do_reset();
    run_event(24'h00AA55, 12'h010, 16'h0102, 12'd4, 2, 1, 0, 0);
    build_exp(24'h00AA55, 12'h010, 16'h0102, 12'd4, 2);
    vectors++;
    if (cap_w.size() != exp_w.size()) begin
      miscompares++;
      $display("FAIL pad_count: got %0d words, required %0d", cap_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
      vectors++;
      if (cap_w[i] !== exp_w[i] || cap_t[i] !== (i == exp_w.size() - 1)) begin
        miscompares++;
        $display("FAIL pad_word%0d: got %h t%0b, required %h t%0b", i, cap_w[i], cap_t[i],
                 exp_w[i], i == exp_w.size() - 1);
      end
    end
    vectors++;
    if (len_err_cnt !== 16'd1 || evt_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL pad_cnt: got err %0d evt %0d, required 1 1", len_err_cnt, evt_cnt);
    end
  endtask

  task automatic test_drain();
    do_reset();
    run_event(24'hFEDCBA, 12'hFFF, 16'hFFFF, 12'd1, 3, 2, 0, 0);
    build_exp(24'hFEDCBA, 12'hFFF, 16'hFFFF, 12'd1, 3);
    vectors++;
    if (cap_w.size() != exp_w.size()) begin
      miscompares++;
      $display("FAIL drain_count: got %0d words, required %0d", cap_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
      vectors++;
      if (cap_w[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL drain_word%0d: got %h, required %h", i, cap_w[i], exp_w[i]);
      end
    end
    vectors++;
    if (pl_idx != 3 || len_err_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL drain_consumed: got %0d words read err %0d, required 3 1", pl_idx, len_err_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    run_event(24'h0F0F0F, 12'h123, 16'h4567, 12'd8, 8, 7, 1, 0);
    build_exp(24'h0F0F0F, 12'h123, 16'h4567, 12'd8, 8);
    vectors++;
    if (cap_w.size() != 11) begin
      miscompares++;
      $display("FAIL bp_count: got %0d valid cycles, required 11", cap_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
      vectors++;
      if (cap_w[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL bp_word%0d: got %h, required %h", i, cap_w[i], exp_w[i]);
      end
    end
    vectors++;
    if (gap_viol != 0) begin
      miscompares++;
      $display("FAIL bp_gap: got %0d valids after daq_ready=0, required 0", gap_viol);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_event(24'h111111, 12'h222, 16'h3333, 12'd4, 4, 3, 0, 5);
    reset = 1'b1;
    @(posedge usr_clk);
    @(negedge usr_clk);
    vectors++;
    if ({ev_data_valid, ev_data_header, ev_data_trailer, pl_ready, trg_ready} !== 5'b00001 ||
        ev_data !== 64'h0) begin
      miscompares++;
      $display("FAIL rmid_out: got v%b h%b t%b plr%b trr%b data %h, required 0 0 0 0 1 0",
               ev_data_valid, ev_data_header, ev_data_trailer, pl_ready, trg_ready, ev_data);
    end
    @(posedge usr_clk);
    #1 reset = 1'b0;
    clear_cap();
    run_event(24'h000042, 12'h001, 16'h0005, 12'd1, 1, 0, 0, 0);
    build_exp(24'h000042, 12'h001, 16'h0005, 12'd1, 1);
    vectors++;
    if (cap_w.size() != exp_w.size()) begin
      miscompares++;
      $display("FAIL rmid_count: got %0d words, required %0d", cap_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
      vectors++;
      if (cap_w[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL rmid_word%0d: got %h, required %h", i, cap_w[i], exp_w[i]);
      end
    end
    vectors++;
    if (evt_cnt !== 32'd1 || len_err_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rmid_cnt: got evt %0d err %0d, required 1 0", evt_cnt, len_err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_pad();
    test_drain();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
